// File: rtl/hamming_tx_pkg.sv
// Shared types, bit positions and the Hamming(7,4) encoder
// for the TMR replica transmit path and its matching decoder.
package hamming_tx_pkg;

    localparam int N_LANES = 3;
    localparam int CW_W    = 7;

    // Codeword bit positions, shared with the decoder side
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D0_POS = 2;
    localparam int P4_POS = 3;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;

    typedef logic [CW_W-1:0] codeword_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        INJECT
    } inj_state_t;

    function automatic codeword_t hamming74_enc(input logic [3:0] d);
        codeword_t cw;
        cw         = '0;
        cw[D0_POS] = d[0];
        cw[D1_POS] = d[1];
        cw[D2_POS] = d[2];
        cw[D3_POS] = d[3];
        cw[P1_POS] = d[0] ^ d[1] ^ d[3];
        cw[P2_POS] = d[0] ^ d[2] ^ d[3];
        cw[P4_POS] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a counter.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; memory is cleared so idle lanes read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hamming_tmr_tx.sv
// Hamming(7,4) encoder feeding three replica lanes, with a
// fault-injection sequencer that flips one bit in one lane.
module hamming_tmr_tx
    import hamming_tx_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_lane_a,
    output logic [6:0]       out_lane_b,
    output logic [6:0]       out_lane_c,
    input  logic             inj_arm,
    input  logic [1:0]       inj_lane,
    input  logic [2:0]       inj_bit,
    input  logic [3:0]       inj_count,
    output logic             inj_busy,
    output logic [CNT_W-1:0] words_sent
);

    inj_state_t state_q, state_d;
    logic [1:0] lane_q, lane_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sent_q;

    logic      full, empty, push, pop, stalled, arm_ok;
    codeword_t head, bit_mask;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign stalled   = out_valid && !out_ready;
    assign arm_ok    = inj_arm && (inj_lane != 2'd3) &&
                       (inj_bit != 3'd7) && (inj_count != 4'd0);

    sync_fifo #(
        .WIDTH (CW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (hamming74_enc(in_data)),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign bit_mask = codeword_t'(1) << bit_q;

    // Lane corruption only while injecting, only on the chosen lane
    always_comb begin
        out_lane_a = head;
        out_lane_b = head;
        out_lane_c = head;
        if (state_q == INJECT) begin
            unique case (lane_q)
                2'd0:    out_lane_a = head ^ bit_mask;
                2'd1:    out_lane_b = head ^ bit_mask;
                2'd2:    out_lane_c = head ^ bit_mask;
                default: ;
            endcase
        end
    end

    // Sequencer next-state, field latching and burst countdown
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arm_ok) begin
                    lane_d  = inj_lane;
                    bit_d   = inj_bit;
                    cnt_d   = inj_count;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // Never corrupt a word already being presented
                if (!stalled) begin
                    state_d = INJECT;
                end
            end
            INJECT: begin
                if (pop) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating count of output handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q <= '0;
        end else if (pop && (sent_q != '1)) begin
            sent_q <= sent_q + CNT_W'(1);
        end
    end

    assign inj_busy   = (state_q != IDLE);
    assign words_sent = sent_q;

endmodule

// File: tb/tb_hamming_tmr_tx.sv
// Directed bench for hamming_tmr_tx: encoding, back-pressure,
// injection bursts, invalid arm requests and mid-burst reset.
module tb_hamming_tmr_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_lane_a;
    logic [6:0]  out_lane_b;
    logic [6:0]  out_lane_c;
    logic        inj_arm;
    logic [1:0]  inj_lane;
    logic [2:0]  inj_bit;
    logic [3:0]  inj_count;
    logic        inj_busy;
    logic [15:0] words_sent;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_tmr_tx #(
        .DEPTH (2),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lane_a (out_lane_a),
        .out_lane_b (out_lane_b),
        .out_lane_c (out_lane_c),
        .inj_arm    (inj_arm),
        .inj_lane   (inj_lane),
        .inj_bit    (inj_bit),
        .inj_count  (inj_count),
        .inj_busy   (inj_busy),
        .words_sent (words_sent)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input string tag, input logic [6:0] a,
                         input logic [6:0] b, input logic [6:0] c);
        check({tag, "_a"}, 32'(out_lane_a), 32'(a));
        check({tag, "_b"}, 32'(out_lane_b), 32'(b));
        check({tag, "_c"}, 32'(out_lane_c), 32'(c));
    endtask

    task automatic push1(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic arm(input logic [1:0] l, input logic [2:0] b,
                       input logic [3:0] n);
        inj_arm   = 1'b1;
        inj_lane  = l;
        inj_bit   = b;
        inj_count = n;
        tick();
        inj_arm   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        inj_arm = 1'b0; inj_lane = '0; inj_bit = '0; inj_count = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(inj_busy), 32'd0);
        check("rst_sent", 32'(words_sent), 32'd0);
        lanes("rst", 7'b0, 7'b0, 7'b0);

        // 1: single word, one-cycle latency
        out_ready = 1'b1;
        push1(4'b1010);
        check("t1_valid", 32'(out_valid), 32'd1);
        lanes("t1", 7'b1010010, 7'b1010010, 7'b1010010);
        tick();
        check("t1_sent", 32'(words_sent), 32'd1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // 2: back-pressure, full FIFO, in-order drain
        out_ready = 1'b0;
        push1(4'b1100);
        check("t2_ready1", 32'(in_ready), 32'd1);
        push1(4'b0000);
        check("t2_full", 32'(in_ready), 32'd0);
        tick();
        lanes("t2_hold", 7'b1100001, 7'b1100001, 7'b1100001);
        in_valid = 1'b1; in_data = 4'b1111; out_ready = 1'b1;
        tick();
        check("t2_reready", 32'(in_ready), 32'd1);
        lanes("t2_w1", 7'b0000000, 7'b0000000, 7'b0000000);
        tick();
        in_valid = 1'b0;
        lanes("t2_w2", 7'b1111111, 7'b1111111, 7'b1111111);
        tick();
        check("t2_drained", 32'(out_valid), 32'd0);
        check("t2_sent", 32'(words_sent), 32'd4);

        // 3: burst of two on lane b bit 2
        arm(2'd1, 3'd2, 4'd2);
        check("t3_armed", 32'(inj_busy), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            push1(4'b1010);
            if (i < 2)
                lanes("t3_bad", 7'b1010010, 7'b1010110, 7'b1010010);
            else
                lanes("t3_ok", 7'b1010010, 7'b1010010, 7'b1010010);
            tick();
            if (i == 0) check("t3_busy0", 32'(inj_busy), 32'd1);
            if (i == 1) check("t3_busy1", 32'(inj_busy), 32'd0);
        end
        check("t3_sent", 32'(words_sent), 32'd8);

        // 4: arming while a word is stalled
        out_ready = 1'b0;
        push1(4'b1010);
        lanes("t4_pre", 7'b1010010, 7'b1010010, 7'b1010010);
        arm(2'd0, 3'd0, 4'd1);
        check("t4_armed", 32'(inj_busy), 32'd1);
        lanes("t4_arm", 7'b1010010, 7'b1010010, 7'b1010010);
        tick();
        lanes("t4_stall", 7'b1010010, 7'b1010010, 7'b1010010);
        out_ready = 1'b1;
        tick();
        check("t4_popped", 32'(out_valid), 32'd0);
        push1(4'b1010);
        lanes("t4_bad", 7'b1010011, 7'b1010010, 7'b1010010);
        tick();
        check("t4_done", 32'(inj_busy), 32'd0);

        // 5: invalid arm requests are ignored
        arm(2'd3, 3'd1, 4'd1);
        check("t5_lane3", 32'(inj_busy), 32'd0);
        arm(2'd0, 3'd7, 4'd1);
        check("t5_bit7", 32'(inj_busy), 32'd0);
        arm(2'd1, 3'd1, 4'd0);
        check("t5_cnt0", 32'(inj_busy), 32'd0);
        tick();
        push1(4'b1111);
        lanes("t5_clean", 7'b1111111, 7'b1111111, 7'b1111111);
        tick();
        check("t5_sent", 32'(words_sent), 32'd11);

        // 6: reset in the middle of a burst
        arm(2'd2, 3'd6, 4'd3);
        tick();
        out_ready = 1'b0;
        push1(4'b1100);
        push1(4'b0000);
        check("t6_full", 32'(in_ready), 32'd0);
        lanes("t6_bad", 7'b1100001, 7'b1100001, 7'b0100001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(inj_busy), 32'd0);
        check("t6_sent", 32'(words_sent), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        lanes("t6_lanes", 7'b0, 7'b0, 7'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
